// File: rtl/stack_unit.sv
// Hardware stack engine: pushes/pops register, flags or two-word PC operands
// through a single-port data memory with a descending, post-decrement stack pointer.
module stack_unit #(
   parameter int SP_W = 12
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [1:0]      src_sel,
   input  logic [15:0]     reg_data,
   input  logic [31:0]     pc_in,
   input  logic [2:0]      flags_in,
   output logic            mem_we,
   output logic            mem_re,
   output logic [SP_W-1:0] mem_addr,
   output logic [15:0]     mem_wdata,
   input  logic [15:0]     mem_rdata,
   output logic            busy,
   output logic            done,
   output logic [15:0]     pop_data,
   output logic [31:0]     pc_out,
   output logic            pc_load,
   output logic [2:0]      flags_out,
   output logic            flag_load,
   output logic [SP_W-1:0] sp,
   output logic            ovf_err,
   output logic            unf_err,
   output logic            cmd_err
);

   typedef enum logic [2:0] {IDLE, W1, W2, R1, R2, RL} state_t;

   localparam logic [SP_W-1:0] SP_TOP    = '1;
   localparam logic [1:0]      SRC_FLAGS = 2'b00;
   localparam logic [1:0]      SRC_PC    = 2'b01;
   localparam logic [1:0]      SRC_RSV   = 2'b10;
   localparam logic [1:0]      SRC_REG   = 2'b11;

   state_t          state_q, state_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic [1:0]      cls_q, cls_d;
   logic [31:0]     op_q, op_d;
   logic [15:0]     lower_q, lower_d;
   logic [15:0]     pop_data_q, pop_data_d;
   logic [31:0]     pc_out_q, pc_out_d;
   logic [2:0]      flags_out_q, flags_out_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic            cmd_q, cmd_d;
   logic [SP_W-1:0] need;
   logic [SP_W-1:0] headroom;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sp_q        <= SP_TOP;
         cls_q       <= SRC_FLAGS;
         op_q        <= '0;
         lower_q     <= '0;
         pop_data_q  <= '0;
         pc_out_q    <= '0;
         flags_out_q <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         cmd_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         cls_q       <= cls_d;
         op_q        <= op_d;
         lower_q     <= lower_d;
         pop_data_q  <= pop_data_d;
         pc_out_q    <= pc_out_d;
         flags_out_q <= flags_out_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         cmd_q       <= cmd_d;
      end
   end

   assign need     = (src_sel == SRC_PC) ? SP_W'(2) : SP_W'(1);
   assign headroom = SP_TOP - sp_q;

   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      cls_d     = cls_q;
      op_d      = op_q;
      lower_d   = lower_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      cmd_d     = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = sp_q;
      mem_wdata = '0;
      done      = 1'b0;
      pc_load   = 1'b0;
      flag_load = 1'b0;
      pop_data  = pop_data_q;
      pc_out    = pc_out_q;
      flags_out = flags_out_q;

      case (state_q)
         IDLE: begin
            if (push || pop) begin
               if ((push && pop) || src_sel == SRC_RSV) begin
                  cmd_d = 1'b1;
               end else if (push) begin
                  if (sp_q < need) begin
                     ovf_d = 1'b1;
                  end else begin
                     state_d = W1;
                     cls_d   = src_sel;
                     if (src_sel == SRC_PC)       op_d = pc_in;
                     else if (src_sel == SRC_REG) op_d = {16'h0, reg_data};
                     else                         op_d = {29'h0, flags_in};
                  end
               end else begin
                  if (headroom < need) begin
                     unf_d = 1'b1;
                  end else begin
                     state_d = R1;
                     cls_d   = src_sel;
                  end
               end
            end
         end
         W1: begin
            // A PC goes out upper half first so the lower half sits at the lower address.
            mem_we    = 1'b1;
            mem_wdata = (cls_q == SRC_PC) ? op_q[31:16] : op_q[15:0];
            sp_d      = sp_q - 1'b1;
            if (cls_q == SRC_PC) begin
               state_d = W2;
            end else begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         W2: begin
            mem_we    = 1'b1;
            mem_wdata = op_q[15:0];
            sp_d      = sp_q - 1'b1;
            done      = 1'b1;
            state_d   = IDLE;
         end
         R1: begin
            mem_re   = 1'b1;
            mem_addr = sp_q + 1'b1;
            sp_d     = sp_q + 1'b1;
            state_d  = (cls_q == SRC_PC) ? R2 : RL;
         end
         R2: begin
            lower_d  = mem_rdata;
            mem_re   = 1'b1;
            mem_addr = sp_q + 1'b1;
            sp_d     = sp_q + 1'b1;
            state_d  = RL;
         end
         RL: begin
            // Popped value is bypassed so it is visible alongside its load pulse.
            done    = 1'b1;
            state_d = IDLE;
            case (cls_q)
               SRC_PC: begin
                  pc_out  = {mem_rdata, lower_q};
                  pc_load = 1'b1;
               end
               SRC_FLAGS: begin
                  flags_out = mem_rdata[2:0];
                  flag_load = 1'b1;
               end
               default: pop_data = mem_rdata;
            endcase
         end
         default: state_d = IDLE;
      endcase

      pop_data_d  = pop_data;
      pc_out_d    = pc_out;
      flags_out_d = flags_out;
   end

   assign busy    = (state_q != IDLE);
   assign sp      = sp_q;
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
   assign cmd_err = cmd_q;

endmodule
